// File: rtl/noise_mixer_pkg.sv
// Shared types and helpers for the noise mixer: FSM state encoding,
// noise-level width decode and default saturation bounds.
package noise_mixer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} mix_state_e;

  localparam int unsigned PKG_DATA_W  = 16;
  localparam int          PKG_SAT_MAX = (2 ** (PKG_DATA_W - 1)) - 1;
  localparam int          PKG_SAT_MIN = -(2 ** (PKG_DATA_W - 1));

  // Active LFSR width for each noise-level code; matches the LFSR's own decode.
  function automatic int unsigned sel2width(input logic [1:0] sel);
    case (sel)
      2'd3:    return 24;
      2'd2:    return 22;
      2'd1:    return 20;
      default: return 18;
    endcase
  endfunction

endpackage

// File: rtl/noise_mixer_sat_add.sv
// Combinational signed adder with clamp to an OUT_W-bit signed range and a
// flag that reports whether the clamp was applied.
module sat_add #(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] sum_o,
  output logic                    sat_o
);

  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(-(64'sd1 <<< (OUT_W - 1)));

  logic signed [IN_W:0] full;

  // One extra bit keeps the raw sum exact before the range check.
  always_comb begin
    full  = (IN_W+1)'(a_i) + (IN_W+1)'(b_i);
    sum_o = full[OUT_W-1:0];
    sat_o = 1'b0;
    if (full > MAX_V) begin
      sum_o = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (full < MIN_V) begin
      sum_o = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/noise_mixer.sv
// Adds centred, scaled LFSR noise to clean samples, saturates, and streams the
// result downstream. Optional saturation counter: NOISE_MIXER_SAT_CNT_EN.
module noise_mixer
  import noise_mixer_pkg::*;
#(
  parameter int unsigned DATA_W      = PKG_DATA_W,
  parameter int unsigned NOISE_W     = 24,
  parameter int unsigned NOISE_SHIFT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [1:0]         i_sel,
  input  logic [NOISE_W-1:0] i_noise,
  output logic               o_lfsr_en,
  input  logic [DATA_W-1:0]  i_sig,
  input  logic               i_sig_vld,
  output logic               o_sig_rdy,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic               o_sat,
  output logic               o_busy,
  output logic [15:0]        o_sat_cnt
);

  localparam int unsigned SUM_W = DATA_W + 2;

  mix_state_e               state_q;
  logic                     vld_q;
  logic                     sat_q;
  logic [DATA_W-1:0]        data_q;
  logic                     accept;

  logic [NOISE_W:0]         half;
  logic signed [NOISE_W:0]  n_c;
  logic signed [NOISE_W:0]  n_sh;
  logic signed [SUM_W-1:0]  n_s;
  logic signed [SUM_W-1:0]  sig_x;
  logic signed [DATA_W-1:0] sum_d;
  logic                     sat_d;

  // Centre the noise on zero for the active width, then scale it down.
  always_comb begin
    half  = (NOISE_W+1)'(1) << (sel2width(i_sel) - 1);
    n_c   = $signed({1'b0, i_noise}) - $signed(half);
    n_sh  = n_c >>> NOISE_SHIFT;
    n_s   = SUM_W'(n_sh);
    sig_x = SUM_W'($signed(i_sig));
  end

  sat_add #(
    .IN_W  (SUM_W),
    .OUT_W (DATA_W)
  ) u_sat_add (
    .a_i   (sig_x),
    .b_i   (n_s),
    .sum_o (sum_d),
    .sat_o (sat_d)
  );

  assign o_sig_rdy = (state_q == RUN) & (~vld_q | i_rdy);
  assign accept    = i_sig_vld & o_sig_rdy;
  assign o_lfsr_en = accept;
  assign o_busy    = (state_q != IDLE);
  assign o_data    = data_q;
  assign o_vld     = vld_q;
  assign o_sat     = sat_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE:    if (i_start && !i_stop) state_q <= RUN;
        RUN:     if (i_stop) state_q <= DRAIN;
        DRAIN:   if (!vld_q || i_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // New accept overwrites the slot in the same cycle it drains.
      if (accept) begin
        data_q <= sum_d;
        sat_q  <= sat_d;
        vld_q  <= 1'b1;
      end else if (i_rdy) begin
        vld_q  <= 1'b0;
      end
    end
  end

`ifdef NOISE_MIXER_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_cnt_q <= '0;
    end else if (i_start) begin
      sat_cnt_q <= '0;
    end else if (accept && sat_d && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`else
  assign o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_noise_mixer.sv
// Self-checking bench for noise_mixer: scoreboard of expected outputs pushed on
// accept and compared when the sample leaves the output register.
module tb_noise_mixer;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_stop;
  logic [1:0]  i_sel;
  logic [23:0] i_noise;
  logic        o_lfsr_en;
  logic [15:0] i_sig;
  logic        i_sig_vld;
  logic        o_sig_rdy;
  logic [15:0] o_data;
  logic        o_vld;
  logic        i_rdy;
  logic        o_sat;
  logic        o_busy;
  logic [15:0] o_sat_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  bit          auto_push = 1'b1;
  logic        xfer;
  logic [15:0] xd;
  logic        xs;
  logic [15:0] exp_cnt = '0;
  int          n_push = 0;
  int          n_pop  = 0;

  noise_mixer #(
    .DATA_W      (16),
    .NOISE_W     (24),
    .NOISE_SHIFT (8)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_sel     (i_sel),
    .i_noise   (i_noise),
    .o_lfsr_en (o_lfsr_en),
    .i_sig     (i_sig),
    .i_sig_vld (i_sig_vld),
    .o_sig_rdy (o_sig_rdy),
    .o_data    (o_data),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_sat     (o_sat),
    .o_busy    (o_busy),
    .o_sat_cnt (o_sat_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t model(input logic [15:0] s, input logic [23:0] nz, input logic [1:0] sl);
    exp_t m;
    int k, nc, ns, sum;
    k   = (sl == 2'd3) ? 24 : (sl == 2'd2) ? 22 : (sl == 2'd1) ? 20 : 18;
    nc  = int'(nz) - (1 << (k - 1));
    ns  = nc >>> 8;
    sum = int'($signed(s)) + ns;
    if (sum > 32767) begin
      m.data = 16'h7FFF; m.sat = 1'b1;
    end else if (sum < -32768) begin
      m.data = 16'h8000; m.sat = 1'b1;
    end else begin
      m.data = 16'(sum); m.sat = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [15:0] cnt_ref();
`ifdef NOISE_MIXER_SAT_CNT_EN
    return exp_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Called at a negedge with inputs settled; records the transfer and accept of the coming edge.
  task automatic tick();
    exp_t m;
    xfer = o_vld & i_rdy;
    xd   = o_data;
    xs   = o_sat;
    if (i_sig_vld && o_sig_rdy && auto_push) begin
      m = model(i_sig, i_noise, i_sel);
      sb.push_back(m);
      n_push++;
      if (m.sat && exp_cnt != 16'hFFFF) exp_cnt++;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic rand_drive();
    int k;
    i_sel     = 2'($urandom_range(0, 3));
    k         = (i_sel == 2'd3) ? 24 : (i_sel == 2'd2) ? 22 : (i_sel == 2'd1) ? 20 : 18;
    i_noise   = 24'($urandom & ((32'd1 << k) - 32'd1));
    i_sig     = 16'($urandom);
    i_sig_vld = 1'b1;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    #1;
    tick();
    i_start = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    n_checks++; if (o_data    !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", o_data); end
    n_checks++; if (o_vld     !== 1'b0)  begin n_fail++; $display("FAIL reset_vld: got %b expected 0", o_vld); end
    n_checks++; if (o_sat     !== 1'b0)  begin n_fail++; $display("FAIL reset_sat: got %b expected 0", o_sat); end
    n_checks++; if (o_sat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", o_sat_cnt); end
    n_checks++; if (o_lfsr_en !== 1'b0)  begin n_fail++; $display("FAIL reset_lfsr_en: got %b expected 0", o_lfsr_en); end
    n_checks++; if (o_sig_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_sig_rdy: got %b expected 0", o_sig_rdy); end
    n_checks++; if (o_busy    !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_single(input string name, input logic [1:0] sel, input logic [23:0] noise,
                             input logic [15:0] sig, input logic [15:0] exp_data, input logic exp_sat);
    exp_t e;
    i_rdy = 1'b1; i_sel = sel; i_noise = noise; i_sig = sig; i_sig_vld = 1'b1;
    #1;
    n_checks++; if (o_lfsr_en !== 1'b1) begin n_fail++; $display("FAIL %s_lfsr_en: got %b expected 1", name, o_lfsr_en); end
    sb.push_back('{data: exp_data, sat: exp_sat});
    n_push++;
    if (exp_sat && exp_cnt != 16'hFFFF) exp_cnt++;
    auto_push = 1'b0;
    tick();
    auto_push = 1'b1;
    i_sig_vld = 1'b0;
    #1;
    n_checks++; if (o_vld !== 1'b1) begin n_fail++; $display("FAIL %s_vld: got %b expected 1", name, o_vld); end
    tick();
    n_checks++;
    if (!xfer || sb.size() == 0) begin
      n_fail++; $display("FAIL %s_xfer: got xfer=%b expected 1", name, xfer);
    end else begin
      e = sb.pop_front(); n_pop++;
      n_checks++; if (xd !== e.data) begin n_fail++; $display("FAIL %s_data: got %h expected %h", name, xd, e.data); end
      n_checks++; if (xs !== e.sat)  begin n_fail++; $display("FAIL %s_sat: got %b expected %b", name, xs, e.sat); end
    end
    n_checks++; if (o_sat_cnt !== cnt_ref()) begin n_fail++; $display("FAIL %s_cnt: got %h expected %h", name, o_sat_cnt, cnt_ref()); end
    n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL %s_vld_clear: got %b expected 0", name, o_vld); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] held;
    logic        held_sat;
    i_rdy = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 6) begin
        i_rdy    = 1'b0;
        held     = o_data;
        held_sat = o_sat;
      end
      if (c == 11) i_rdy = 1'b1;
      if (c < 19) rand_drive(); else i_sig_vld = 1'b0;
      #1;
      if (c >= 6 && c < 11) begin
        n_checks++; if (o_sig_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_sig_rdy: got %b expected 0 cycle %0d", o_sig_rdy, c); end
        n_checks++; if (o_lfsr_en !== 1'b0) begin n_fail++; $display("FAIL bp_lfsr_en: got %b expected 0 cycle %0d", o_lfsr_en, c); end
        n_checks++; if (o_data !== held || o_sat !== held_sat) begin
          n_fail++; $display("FAIL bp_hold: got %h/%b expected %h/%b cycle %0d", o_data, o_sat, held, held_sat, c);
        end
      end else if (c < 19) begin
        n_checks++; if (o_lfsr_en !== 1'b1) begin n_fail++; $display("FAIL stream_lfsr_en: got %b expected 1 cycle %0d", o_lfsr_en, c); end
      end
      tick();
      if (xfer) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got unexpected sample %h expected none", xd);
        end else begin
          e = sb.pop_front(); n_pop++;
          if (xd !== e.data || xs !== e.sat) begin
            n_fail++; $display("FAIL stream_data: got %h/%b expected %h/%b", xd, xs, e.data, e.sat);
          end
        end
      end
    end
    n_checks++; if (sb.size() != 0 || n_pop != n_push) begin
      n_fail++; $display("FAIL stream_count: got %0d delivered expected %0d", n_pop, n_push);
    end
    n_checks++; if (o_sat_cnt !== cnt_ref()) begin n_fail++; $display("FAIL stream_cnt: got %h expected %h", o_sat_cnt, cnt_ref()); end
  endtask

  task automatic test_stop();
    exp_t e;
    i_rdy = 1'b0;
    rand_drive();
    #1;
    tick();
    i_sig_vld = 1'b0;
    i_stop    = 1'b1;
    #1;
    tick();
    i_stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (o_busy !== 1'b1 || o_vld !== 1'b1) begin
        n_fail++; $display("FAIL drain_hold: got busy=%b vld=%b expected 1/1", o_busy, o_vld);
      end
      n_checks++; if (o_sig_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_sig_rdy: got %b expected 0", o_sig_rdy); end
      tick();
    end
    i_rdy = 1'b1;
    #1;
    tick();
    n_checks++;
    if (!xfer || sb.size() == 0) begin
      n_fail++; $display("FAIL drain_xfer: got xfer=%b expected 1", xfer);
    end else begin
      e = sb.pop_front(); n_pop++;
      if (xd !== e.data || xs !== e.sat) begin
        n_fail++; $display("FAIL drain_data: got %h/%b expected %h/%b", xd, xs, e.data, e.sat);
      end
    end
    n_checks++; if (o_busy !== 1'b0 || o_vld !== 1'b0) begin
      n_fail++; $display("FAIL drain_idle: got busy=%b vld=%b expected 0/0", o_busy, o_vld);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    i_rdy = 1'b0;
    i_sel = 2'd3; i_noise = 24'h000000; i_sig = 16'h8000; i_sig_vld = 1'b1;
    #1;
    tick();
    i_sig_vld = 1'b0;
    n_checks++; if (o_vld !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pending: got vld=%b busy=%b expected 1/1", o_vld, o_busy);
    end
    #2 i_rst_n = 1'b0;
    #1;
    sb.delete();
    test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_sel = 2'd0; i_noise = '0;
    i_sig = '0; i_sig_vld = 1'b0; i_rdy = 1'b0;
    repeat (2) @(negedge i_clk);
    test_reset();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    do_start();
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", o_busy); end
    test_single("zero_noise", 2'd3, 24'h800000, 16'h1234, 16'h1234, 1'b0);
    test_single("pos_clip",   2'd3, 24'hFFFFFF, 16'h7F00, 16'h7FFF, 1'b1);
    test_single("neg_clip",   2'd3, 24'h000000, 16'h8000, 16'h8000, 1'b1);
    test_single("level_sel0", 2'd0, 24'h03FFFF, 16'h0000, 16'h01FF, 1'b0);
    test_single("level_sel3", 2'd3, 24'h03FFFF, 16'h0000, 16'h83FF, 1'b0);
    test_back_to_back();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
